fetch_req_sequencer: RTL



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_tag_fifo.sv | 59 +++++
 rtl/fetch_req_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, request-stage states and tracker entry type for the fetch sequencer
package fetch_pkg;

  localparam int NUM_WF          = 40;
  localparam int WF_ID_W         = 6;
  localparam int PC_W            = 32;
  localparam int INSTR_W         = 32;
  localparam int MAX_OUTSTANDING = 4;
  localparam int PTR_W           = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W           = PTR_W + 1;

  localparam logic [0:0] REQ_IDLE = 1'b0;
  localparam logic [0:0] REQ_PEND = 1'b1;

  typedef struct packed {
    logic               squashed;
    logic [WF_ID_W-1:0] wfid;
    logic [PC_W-1:0]    pc;
  } tag_entry_t;

endpackage

// File: rtl/fetch_tag_fifo.sv
// rtl/fetch_tag_fifo.sv - in-order tracker of issued icache requests with squash-by-wave marking
module fetch_tag_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  tag_entry_t         push_entry,
  input  logic               pop,
  input  logic               squash_valid,
  input  logic [WF_ID_W-1:0] squash_wfid,
  output tag_entry_t         head,
  output logic [CNT_W-1:0]   count,
  output logic               empty
);

  tag_entry_t           mem_q [MAX_OUTSTANDING];
  tag_entry_t           mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Squash marks stale slots too; they are never read before being overwritten.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (squash_valid && (mem_q[i].wfid == squash_wfid)) begin
        mem_d[i].squashed = 1'b1;
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_req_sequencer.sv
// rtl/fetch_req_sequencer.sv - registers arbiter fetch picks, issues them to the icache, steers in-order returns
// FETCH_PERF_CNT_EN enables the handshake / squash / stall performance counters.
module fetch_req_sequencer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [WF_ID_W-1:0] sel_wfid,
  input  logic [PC_W-1:0]    sel_pc,
  output logic               sel_ready,
  output logic               icache_req_valid,
  output logic [PC_W-1:0]    icache_req_pc,
  input  logic               icache_req_ready,
  input  logic               icache_rsp_valid,
  input  logic [INSTR_W-1:0] icache_rsp_instr,
  input  logic               flush_valid,
  input  logic [WF_ID_W-1:0] flush_wfid,
  output logic               ib_wr_en,
  output logic [WF_ID_W-1:0] ib_wr_wfid,
  output logic [PC_W-1:0]    ib_wr_pc,
  output logic [INSTR_W-1:0] ib_wr_instr,
  output logic [NUM_WF-1:0]  wf_inflight,
  output logic [CNT_W-1:0]   outstanding_cnt,
  output logic               err_unexpected_rsp,
  output logic [31:0]        perf_req_cnt,
  output logic [31:0]        perf_squash_cnt,
  output logic [31:0]        perf_stall_cnt
);

  logic [0:0]         state_q, state_d;
  logic [WF_ID_W-1:0] req_wfid_q, req_wfid_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic [NUM_WF-1:0]  inflight_q, inflight_d;
  logic               ib_wr_en_q, ib_wr_en_d;
  logic [WF_ID_W-1:0] ib_wr_wfid_q, ib_wr_wfid_d;
  logic [PC_W-1:0]    ib_wr_pc_q, ib_wr_pc_d;
  logic [INSTR_W-1:0] ib_wr_instr_q, ib_wr_instr_d;
  logic               err_q, err_d;

  tag_entry_t         fifo_push_entry;
  tag_entry_t         fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;

  logic               stage_pend;
  logic               flush_hit_req;
  logic               req_hs;
  logic               req_cancel;
  logic               rsp_pop;
  logic               head_squashed;
  logic               rsp_live;
  logic [CNT_W-1:0]   total_cnt;
  logic               sel_wf_ok;
  logic               sel_busy;
  logic               accept;

  assign stage_pend    = (state_q == REQ_PEND);
  assign flush_hit_req = flush_valid && (flush_wfid == req_wfid_q);
  assign req_hs        = stage_pend && icache_req_ready;
  // Once the icache has seen valid with ready, the request is committed; flush then squashes the tracker entry.
  assign req_cancel    = stage_pend && !icache_req_ready && flush_hit_req;
  assign rsp_pop       = icache_rsp_valid && !fifo_empty;
  assign head_squashed = fifo_head.squashed || (flush_valid && (flush_wfid == fifo_head.wfid));
  assign rsp_live      = rsp_pop && !head_squashed;
  assign total_cnt     = CNT_W'(stage_pend) + fifo_count;
  assign sel_wf_ok     = (sel_wfid < WF_ID_W'(NUM_WF));
  assign sel_busy      = sel_wf_ok ? inflight_q[sel_wfid] : 1'b1;

  assign accept = !rst && sel_valid && (!stage_pend || req_hs)
               && ((total_cnt < CNT_W'(MAX_OUTSTANDING)) || rsp_pop)
               && !sel_busy
               && !(flush_valid && (flush_wfid == sel_wfid));

  assign fifo_push_entry = '{squashed: flush_hit_req, wfid: req_wfid_q, pc: req_pc_q};

  fetch_tag_fifo u_tag_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (req_hs),
    .push_entry   (fifo_push_entry),
    .pop          (rsp_pop),
    .squash_valid (flush_valid),
    .squash_wfid  (flush_wfid),
    .head         (fifo_head),
    .count        (fifo_count),
    .empty        (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    req_wfid_d    = req_wfid_q;
    req_pc_d      = req_pc_q;
    inflight_d    = inflight_q;
    ib_wr_en_d    = rsp_live;
    ib_wr_wfid_d  = ib_wr_wfid_q;
    ib_wr_pc_d    = ib_wr_pc_q;
    ib_wr_instr_d = ib_wr_instr_q;
    err_d         = err_q || (icache_rsp_valid && fifo_empty);

    if (accept) begin
      state_d    = REQ_PEND;
      req_wfid_d = sel_wfid;
      req_pc_d   = sel_pc;
    end else if (req_hs || req_cancel) begin
      state_d = REQ_IDLE;
    end

    if (rsp_live) begin
      ib_wr_wfid_d  = fifo_head.wfid;
      ib_wr_pc_d    = fifo_head.pc;
      ib_wr_instr_d = icache_rsp_instr;
      inflight_d[fifo_head.wfid] = 1'b0;
    end
    if (flush_valid && (flush_wfid < WF_ID_W'(NUM_WF))) begin
      inflight_d[flush_wfid] = 1'b0;
    end
    if (accept) begin
      inflight_d[sel_wfid] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= REQ_IDLE;
      req_wfid_q    <= '0;
      req_pc_q      <= '0;
      inflight_q    <= '0;
      ib_wr_en_q    <= 1'b0;
      ib_wr_wfid_q  <= '0;
      ib_wr_pc_q    <= '0;
      ib_wr_instr_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_wfid_q    <= req_wfid_d;
      req_pc_q      <= req_pc_d;
      inflight_q    <= inflight_d;
      ib_wr_en_q    <= ib_wr_en_d;
      ib_wr_wfid_q  <= ib_wr_wfid_d;
      ib_wr_pc_q    <= ib_wr_pc_d;
      ib_wr_instr_q <= ib_wr_instr_d;
      err_q         <= err_d;
    end
  end

  assign sel_ready          = accept;
  assign icache_req_valid   = stage_pend;
  assign icache_req_pc      = req_pc_q;
  assign ib_wr_en           = ib_wr_en_q;
  assign ib_wr_wfid         = ib_wr_wfid_q;
  assign ib_wr_pc           = ib_wr_pc_q;
  assign ib_wr_instr        = ib_wr_instr_q;
  assign wf_inflight        = inflight_q;
  assign outstanding_cnt    = total_cnt;
  assign err_unexpected_rsp = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_squash_q, perf_squash_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_req_d    = perf_req_q + 32'(req_hs);
    perf_squash_d = perf_squash_q + 32'(rsp_pop && head_squashed);
    perf_stall_d  = perf_stall_q + 32'(stage_pend && !icache_req_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_q    <= '0;
      perf_squash_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_req_q    <= perf_req_d;
      perf_squash_q <= perf_squash_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_req_cnt    = perf_req_q;
  assign perf_squash_cnt = perf_squash_q;
  assign perf_stall_cnt  = perf_stall_q;
`else
  assign perf_req_cnt    = '0;
  assign perf_squash_cnt = '0;
  assign perf_stall_cnt  = '0;
`endif

endmodule
